jk_bank_ctrl: RTL and testbench

Sequencing controller for a bank of WIDTH external jk_ff flip-flops, which have no reset of their own. It accepts commands over a valid/ready handshake and drives each flop's j/k pins per cycle to clear, load, count up or count down the bank. It reads the bank back on q_in to verify loads and to flag wrap-around.

---
 rtl/jk_bank_ctrl.sv | 163 ++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: sequences j/k pins of an external reset-less jk_ff bank to
// clear, load, count up or count down, with load readback and wrap flags.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic             load_err,
  output logic             wrapped,
  output logic             illegal
);

  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_UP    = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_VERIFY = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_steps;
  logic             r_done;
  logic             r_load_err;
  logic             r_wrapped;
  logic             r_illegal;

  logic             w_accept;
  logic             w_is_run;
  logic             w_done_next;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_borrow;
  logic [WIDTH-1:0] w_expect;

  assign cmd_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_is_run   = ((cmd_op == OP_UP) || (cmd_op == OP_DOWN)) && (cmd_count != '0);
  assign w_expect   = (r_op == OP_CLEAR) ? '0 : r_data;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign steps_left = r_steps;
  assign load_err   = r_load_err;
  assign wrapped    = r_wrapped;
  assign illegal    = r_illegal;

  // Per-bit toggle enables: bit i toggles when all lower bits are ones (up) or zeros (down)
  always_comb begin
    w_carry     = '0;
    w_borrow    = '0;
    w_carry[0]  = 1'b1;
    w_borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_carry[i]  = w_carry[i-1] & q_in[i-1];
      w_borrow[i] = w_borrow[i-1] & ~q_in[i-1];
    end
  end

  // Next state, done strobe and combinational j/k drive
  always_comb begin
    w_next      = r_state;
    w_done_next = 1'b0;
    j_out       = '0;
    k_out       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((cmd_op == OP_CLEAR) || (cmd_op == OP_LOAD)) begin
            w_next = S_APPLY;
          end else if (w_is_run) begin
            w_next = S_RUN;
          end
        end
      end
      S_APPLY: begin
        w_next = S_VERIFY;
        if (r_op == OP_CLEAR) begin
          k_out = '1;
        end else begin
          j_out = r_data;
          k_out = ~r_data;
        end
      end
      S_VERIFY: begin
        w_next = S_IDLE;
      end
      S_RUN: begin
        if (r_steps <= CNT_W'(1)) begin
          w_next = S_IDLE;
        end
        if (r_op == OP_UP) begin
          j_out = w_carry;
          k_out = w_carry;
        end else begin
          j_out = w_borrow;
          k_out = w_borrow;
        end
      end
      default: w_next = S_IDLE;
    endcase
    w_done_next = (w_next == S_IDLE) && ((r_state != S_IDLE) || w_accept);
    if (rst) begin
      j_out = '0;
      k_out = '0;
    end
  end

  // State, latched command, step counter and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_data     <= '0;
      r_steps    <= '0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
      r_wrapped  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_next;
      if (w_accept) begin
        r_op       <= cmd_op;
        r_data     <= cmd_data;
        r_steps    <= w_is_run ? cmd_count : '0;
        r_load_err <= 1'b0;
        r_wrapped  <= 1'b0;
        r_illegal  <= (cmd_op > OP_DOWN);
      end else if (r_state == S_RUN) begin
        r_steps <= r_steps - CNT_W'(1);
        if ((r_op == OP_UP) && (&q_in)) begin
          r_wrapped <= 1'b1;
        end
        if ((r_op == OP_DOWN) && !(|q_in)) begin
          r_wrapped <= 1'b1;
        end
      end else if (r_state == S_VERIFY) begin
        if (q_in != w_expect) begin
          r_load_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: behavioural jk_ff bank plus an arithmetic model of
// the bank value, latency and flags; directed cases then random commands.
module tb_jk_bank_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;
  logic             load_err;
  logic             wrapped;
  logic             illegal;

  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] fault_j;
  int               n_tests = 0;
  int               n_fail  = 0;
  int               m_q     = 0;

  always #5 clk = ~clk;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .q_in(q_in),
    .j_out(j_out), .k_out(k_out), .busy(busy), .done(done),
    .steps_left(steps_left), .load_err(load_err), .wrapped(wrapped),
    .illegal(illegal)
  );

  // External jk_ff bank; fault_j forces selected j pins low
  always @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      case ({j_out[i] & ~fault_j[i], k_out[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: ;
      endcase
    end
  end
  assign q_in = bank_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command and check latency, busy length, bank value and flags
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] data, input int cnt,
                        input logic [3:0] fault, input bool_check_pulse);
    int   lat, n, nbusy, q_next, dir;
    logic exp_err, exp_wrap, exp_ill;
    lat = 0; dir = 0; q_next = m_q;
    exp_err = 1'b0; exp_wrap = 1'b0; exp_ill = 1'b0;
    case (op)
      3'd1: begin lat = 2; q_next = 0; end
      3'd2: begin
        lat = 2;
        q_next = int'((data & ~fault) | (4'(m_q) & data & fault));
        exp_err = (q_next != int'(data));
      end
      3'd3: if (cnt > 0) begin
        lat = cnt; dir = 1;
        exp_wrap = (m_q + cnt >= 16);
        q_next = (m_q + cnt) % 16;
      end
      3'd4: if (cnt > 0) begin
        lat = cnt; dir = -1;
        exp_wrap = (cnt > m_q);
        q_next = (m_q - cnt + 4096) % 16;
      end
      3'd5, 3'd6, 3'd7: exp_ill = 1'b1;
      default: ;
    endcase

    fault_j   = fault;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = CNT_W'(cnt);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    n = 0; nbusy = 0;
    while (!done && n < 300) begin
      if (busy) nbusy++;
      if (n == 0 && op == 3'd2) check("load_jk", {j_out, k_out}, {data, ~data});
      if (n == 0 && op == 3'd1) check("clear_jk", {j_out, k_out}, {4'h0, 4'hF});
      if (dir != 0) begin
        check("run_q", 32'(bank_q), 32'((m_q + dir * n + 4096) % 16));
        check("run_steps", 32'(steps_left), 32'(cnt - n));
      end
      @(posedge clk); #1; n++;
    end
    check("latency", n, lat);
    check("busy_cycles", nbusy, lat);
    check("bank_q", 32'(bank_q), 32'(q_next));
    check("flags", {load_err, wrapped, illegal}, {exp_err, exp_wrap, exp_ill});
    check("done_state", {busy, cmd_ready, steps_left, j_out, k_out}, {2'b01, 16'h0000});
    if (bool_check_pulse) begin
      @(posedge clk); #1;
      check("done_pulse_width", 32'(done), 32'd0);
    end
    fault_j = '0;
    m_q = q_next;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
    fault_j = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_outputs", {cmd_ready, busy, done, load_err, wrapped, illegal, steps_left},
          32'd0);
    check("rst_jk", {j_out, k_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    do_cmd(3'd1, 4'h0, 0, 4'h0, 1'b1);          // CLEAR
    do_cmd(3'd2, 4'hA, 0, 4'h0, 1'b1);          // LOAD 1010
    do_cmd(3'd1, 4'h0, 0, 4'h0, 1'b1);
    do_cmd(3'd2, 4'hA, 0, 4'h2, 1'b1);          // LOAD with bit1 j stuck low
    do_cmd(3'd2, 4'hD, 0, 4'h0, 1'b1);          // LOAD 1101
    do_cmd(3'd3, 4'h0, 5, 4'h0, 1'b1);          // UP 5 wraps
    do_cmd(3'd2, 4'h2, 0, 4'h0, 1'b1);          // LOAD 0010
    do_cmd(3'd4, 4'h0, 3, 4'h0, 1'b1);          // DOWN 3 wraps
    do_cmd(3'd4, 4'h0, 0, 4'h0, 1'b1);          // DOWN 0
    do_cmd(3'd0, 4'h0, 0, 4'h0, 1'b1);          // NOP

    // Back-to-back: UP 2, then illegal op held valid through RUN
    cmd_op = 3'd3; cmd_count = 8'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 3'd6;
    check("b2b_not_ready_run", {cmd_ready, busy}, 2'b01);
    @(posedge clk); #1;
    check("b2b_still_run", {cmd_ready, busy, illegal}, 3'b010);
    @(posedge clk); #1;
    check("b2b_done_ready", {done, cmd_ready, illegal}, 3'b110);
    check("b2b_q", 32'(bank_q), 32'((m_q + 2) % 16));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_illegal_done", {done, illegal, busy}, 3'b110);
    check("b2b_jk", {j_out, k_out}, 32'd0);
    m_q = (m_q + 2) % 16;
    @(posedge clk); #1;
    check("b2b_pulse", 32'(done), 32'd0);

    // Reset after 4 steps of UP 10
    cmd_op = 3'd3; cmd_count = 8'd10; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_mid_jk", {j_out, k_out, 7'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("rst_mid_state", {busy, done, steps_left}, 32'd0);
    check("rst_mid_q", 32'(bank_q), 32'((m_q + 4) % 16));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_nodone", {done, busy}, 2'b00);
    check("rst_mid_frozen", 32'(bank_q), 32'((m_q + 4) % 16));
    m_q = (m_q + 4) % 16;

    // Random command stream
    for (int it = 0; it < 60; it++) begin
      logic [2:0] r_op;
      logic [3:0] r_data;
      logic [3:0] r_fault;
      int         r_cnt;
      r_op    = 3'($urandom_range(0, 7));
      r_data  = 4'($urandom_range(0, 15));
      r_cnt   = int'($urandom_range(0, 20));
      r_fault = 4'h0;
      if (r_op == 3'd2 && $urandom_range(0, 3) == 0) r_fault = 4'($urandom_range(1, 15));
      do_cmd(r_op, r_data, r_cnt, r_fault, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
